// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: register addresses,
// FSM state encoding and CTRL register bit positions.
package irq_controller_pkg;

   localparam logic [1:0] ADDR_PEND = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd1;
   localparam logic [1:0] ADDR_MODE = 2'd2;
   localparam logic [1:0] ADDR_CTRL = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } irq_state_e;

   localparam int CTRL_EN_BIT = 0;
   localparam int CTRL_ID_LSB = 8;
   localparam int CTRL_ST_LSB = 16;

endpackage

// File: rtl/irq_controller_prio_enc.sv
// Combinational lowest-index priority encoder.
//   req_i   : request vector
//   idx_o   : index of the lowest set bit (0 when none)
//   valid_o : any bit of req_i set
module irq_prio_enc #(
   parameter int N_SRC = 8,
   parameter int ID_W  = 3
) (
   input  logic [N_SRC-1:0] req_i,
   output logic [ID_W-1:0]  idx_o,
   output logic             valid_o
);

   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (req_i[i] && !valid_o) begin
            idx_o   = ID_W'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// External-interrupt source block for the core's coproc0.
// Latches peripheral lines as pending (edge or level per source), masks and
// prioritises them, requests the core and holds off until eret.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_src                   : peripheral interrupt lines
//   i_we/i_addr/i_wdata     : register write port (PEND W1C, MASK, MODE, CTRL)
//   o_rdata                 : combinational read data for i_addr
//   o_irq, o_cause_id       : request and source index to the core
//   i_taken, i_eret         : core handshake
module irq_controller
   import irq_controller_pkg::*;
#(
   parameter int N_SRC = 8,
   parameter int ID_W  = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [N_SRC-1:0] i_src,
   input  logic             i_we,
   input  logic [1:0]       i_addr,
   input  logic [31:0]      i_wdata,
   output logic [31:0]      o_rdata,
   output logic             o_irq,
   input  logic             i_taken,
   input  logic             i_eret,
   output logic [ID_W-1:0]  o_cause_id
);

   logic [N_SRC-1:0] pend_q, pend_d;
   logic [N_SRC-1:0] mask_q, mask_d;
   logic [N_SRC-1:0] mode_q, mode_d;
   logic [N_SRC-1:0] prev_q;
   logic             en_q, en_d;
   logic [ID_W-1:0]  cause_q, cause_d;
   irq_state_e       state_q, state_d;

   logic [N_SRC-1:0] set_v, w1c_v, eret_clr_v, eligible, cause_oh;
   logic [ID_W-1:0]  winner;
   logic             any_eligible;
   logic             unused_wdata;

   assign unused_wdata = |i_wdata;

   irq_prio_enc #(.N_SRC(N_SRC), .ID_W(ID_W)) u_prio (
      .req_i   (eligible),
      .idx_o   (winner),
      .valid_o (any_eligible)
   );

   assign eligible = pend_q & mask_q & {N_SRC{en_q}};
   assign cause_oh = {{(N_SRC-1){1'b0}}, 1'b1} << cause_q;

   // Capture: set conditions always override both clear sources.
   always_comb begin
      set_v      = (mode_q & i_src & ~prev_q) | (~mode_q & i_src);
      w1c_v      = (i_we && i_addr == ADDR_PEND) ? i_wdata[N_SRC-1:0] : '0;
      eret_clr_v = (state_q == ST_SERVICE && i_eret) ? (cause_oh & mode_q) : '0;
      pend_d     = (pend_q & ~w1c_v & ~eret_clr_v) | set_v;
      mask_d     = (i_we && i_addr == ADDR_MASK) ? i_wdata[N_SRC-1:0] : mask_q;
      mode_d     = (i_we && i_addr == ADDR_MODE) ? i_wdata[N_SRC-1:0] : mode_q;
      en_d       = (i_we && i_addr == ADDR_CTRL) ? i_wdata[CTRL_EN_BIT] : en_q;
   end

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      unique case (state_q)
         ST_IDLE: begin
            if (any_eligible) begin
               state_d = ST_REQ;
               cause_d = winner;
            end
         end
         ST_REQ: begin
            // i_taken wins over a simultaneous withdrawal.
            if (i_taken)                   state_d = ST_SERVICE;
            else if (!eligible[cause_q])   state_d = ST_IDLE;
         end
         ST_SERVICE: begin
            if (i_eret) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pend_q  <= '0;
         mask_q  <= '0;
         mode_q  <= '0;
         prev_q  <= '0;
         en_q    <= 1'b0;
         cause_q <= '0;
         state_q <= ST_IDLE;
      end else begin
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         mode_q  <= mode_d;
         prev_q  <= i_src;
         en_q    <= en_d;
         cause_q <= cause_d;
         state_q <= state_d;
      end
   end

   assign o_irq      = (state_q == ST_REQ);
   assign o_cause_id = cause_q;

   always_comb begin
      o_rdata = '0;
      unique case (i_addr)
         ADDR_PEND: o_rdata[N_SRC-1:0] = pend_q;
         ADDR_MASK: o_rdata[N_SRC-1:0] = mask_q;
         ADDR_MODE: o_rdata[N_SRC-1:0] = mode_q;
         default: begin
            o_rdata[CTRL_EN_BIT]          = en_q;
            o_rdata[CTRL_ID_LSB +: ID_W]  = cause_q;
            o_rdata[CTRL_ST_LSB +: 2]     = state_q;
         end
      endcase
   end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

   localparam int N = 8;
   localparam int W = 3;

   logic          clk = 1'b0;
   logic          rst, we, taken, eret;
   logic [N-1:0]  src;
   logic [1:0]    addr;
   logic [31:0]   wdata, rdata;
   logic          irq;
   logic [W-1:0]  cause;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   irq_controller #(.N_SRC(N), .ID_W(W)) dut (
      .i_clk(clk), .i_rst(rst), .i_src(src), .i_we(we), .i_addr(addr),
      .i_wdata(wdata), .o_rdata(rdata), .o_irq(irq), .i_taken(taken),
      .i_eret(eret), .o_cause_id(cause)
   );

   typedef struct {
      logic        rst;
      logic [7:0]  src;
      logic        we;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic        taken;
      logic        eret;
      logic [31:0] exp_rd;
      logic        exp_irq;
      logic [2:0]  exp_cause;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [7:0] s, input logic w,
                      input logic [1:0] a, input logic [31:0] d, input logic t,
                      input logic e, input logic [31:0] rd, input logic i,
                      input logic [2:0] c);
      vec_t v;
      v.rst = r; v.src = s; v.we = w; v.addr = a; v.wdata = d; v.taken = t;
      v.eret = e; v.exp_rd = rd; v.exp_irq = i; v.exp_cause = c;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic [7:0] s, input logic w,
                        input logic [1:0] a, input logic [31:0] d,
                        input logic t, input logic e);
      rst = r; src = s; we = w; addr = a; wdata = d; taken = t; eret = e;
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model (spec-level, per-source loop) -------
   int   m_state;            // 0 idle, 1 requesting, 2 in service
   int   m_cause;
   bit   m_pend[N], m_mask[N], m_mode[N], m_prev[N];
   bit   m_en;

   function automatic logic [31:0] m_read(input logic [1:0] a);
      logic [31:0] v = 0;
      for (int i = 0; i < N; i++) begin
         if (a == 0 && m_pend[i]) v += 32'(1) << i;
         if (a == 1 && m_mask[i]) v += 32'(1) << i;
         if (a == 2 && m_mode[i]) v += 32'(1) << i;
      end
      if (a == 3) v = 32'(m_en) + 32'(m_cause) * 256 + 32'(m_state) * 65536;
      return v;
   endfunction

   task automatic m_step(input logic r, input logic [7:0] s, input logic w,
                         input logic [1:0] a, input logic [31:0] d,
                         input logic t, input logic e);
      bit elig[N];
      int win = -1;
      int nstate = m_state;
      int ncause = m_cause;
      bit npend[N];
      if (r) begin
         m_state = 0; m_cause = 0; m_en = 0;
         for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_mask[i] = 0; m_mode[i] = 0; m_prev[i] = 0;
         end
         return;
      end
      for (int i = 0; i < N; i++) begin
         elig[i] = m_pend[i] && m_mask[i] && m_en;
         if (elig[i] && win < 0) win = i;
      end
      if (m_state == 0 && win >= 0) begin nstate = 1; ncause = win; end
      else if (m_state == 1 && t) nstate = 2;
      else if (m_state == 1 && !elig[m_cause]) nstate = 0;
      else if (m_state == 2 && e) nstate = 0;
      for (int i = 0; i < N; i++) begin
         bit setc = m_mode[i] ? (s[i] && !m_prev[i]) : s[i];
         bit clr  = (w && a == 0 && d[i]) ||
                    (m_state == 2 && e && m_cause == i && m_mode[i]);
         npend[i] = setc ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
      end
      for (int i = 0; i < N; i++) begin
         m_pend[i] = npend[i];
         if (w && a == 1) m_mask[i] = d[i];
         if (w && a == 2) m_mode[i] = d[i];
         m_prev[i] = s[i];
      end
      if (w && a == 3) m_en = d[0];
      m_state = nstate;
      m_cause = ncause;
   endtask

   initial begin
      // rst src we addr wdata taken eret | exp_rd exp_irq exp_cause
      // reset and blank reads
      add(1, 8'h00, 0, 0, 0, 0, 0, 32'h0, 0, 0);
      add(0, 8'h00, 0, 1, 0, 0, 0, 32'h0, 0, 0);
      add(0, 8'h00, 0, 2, 0, 0, 0, 32'h0, 0, 0);
      add(0, 8'h00, 0, 3, 0, 0, 0, 32'h0, 0, 0);
      // edge source 0 full handshake
      add(0, 8'h00, 1, 2, 32'h01, 0, 0, 32'h01, 0, 0);
      add(0, 8'h00, 1, 1, 32'h01, 0, 0, 32'h01, 0, 0);
      add(0, 8'h00, 1, 3, 32'hFFFF_FF01, 0, 0, 32'h00001, 0, 0);
      add(0, 8'h01, 0, 0, 0, 0, 0, 32'h01, 0, 0);
      add(0, 8'h00, 0, 3, 0, 0, 0, 32'h10001, 1, 0);
      add(0, 8'h00, 0, 3, 0, 1, 0, 32'h20001, 0, 0);
      add(0, 8'h00, 0, 0, 0, 0, 1, 32'h00, 0, 0);
      add(0, 8'h00, 0, 3, 0, 0, 0, 32'h00001, 0, 0);
      // level mode, priority 3 over 5, W1C then eret
      add(0, 8'h00, 1, 2, 32'h00, 0, 0, 32'h00, 0, 0);
      add(0, 8'h28, 1, 1, 32'hFF, 0, 0, 32'hFF, 0, 0);
      add(0, 8'h28, 0, 0, 0, 0, 0, 32'h28, 1, 3);
      add(0, 8'h28, 0, 3, 0, 1, 0, 32'h20301, 0, 3);
      add(0, 8'h20, 1, 0, 32'h08, 0, 0, 32'h20, 0, 3);
      add(0, 8'h20, 0, 3, 0, 0, 1, 32'h00301, 0, 3);
      add(0, 8'h20, 0, 3, 0, 0, 0, 32'h10501, 1, 5);
      // withdrawal of source 2 by masking
      add(0, 8'h00, 0, 3, 0, 1, 0, 32'h20501, 0, 5);
      add(0, 8'h00, 1, 0, 32'hFF, 0, 1, 32'h00, 0, 5);
      add(0, 8'h04, 0, 0, 0, 0, 0, 32'h04, 0, 5);
      add(0, 8'h00, 0, 3, 0, 0, 0, 32'h10201, 1, 2);
      add(0, 8'h00, 1, 1, 32'h00, 0, 0, 32'h00, 1, 2);
      add(0, 8'h00, 0, 3, 0, 0, 0, 32'h00201, 0, 2);
      add(0, 8'h00, 0, 0, 0, 0, 0, 32'h04, 0, 2);
      // edge source 1: new edge coinciding with eret, then with W1C
      add(0, 8'h00, 1, 0, 32'hFF, 0, 0, 32'h00, 0, 2);
      add(0, 8'h00, 1, 2, 32'h02, 0, 0, 32'h02, 0, 2);
      add(0, 8'h00, 1, 1, 32'h02, 0, 0, 32'h02, 0, 2);
      add(0, 8'h02, 0, 0, 0, 0, 0, 32'h02, 0, 2);
      add(0, 8'h02, 0, 3, 0, 0, 0, 32'h10101, 1, 1);
      add(0, 8'h00, 0, 3, 0, 1, 0, 32'h20101, 0, 1);
      add(0, 8'h02, 0, 0, 0, 0, 1, 32'h02, 0, 1);
      add(0, 8'h00, 0, 3, 0, 0, 0, 32'h10101, 1, 1);
      add(0, 8'h00, 0, 3, 0, 1, 0, 32'h20101, 0, 1);
      add(0, 8'h00, 0, 0, 0, 0, 1, 32'h00, 0, 1);
      add(0, 8'h02, 1, 0, 32'h02, 0, 0, 32'h02, 0, 1);
      // reset while requesting with everything pending
      add(0, 8'hFF, 1, 1, 32'hFF, 0, 0, 32'hFF, 1, 1);
      add(0, 8'hFF, 0, 0, 0, 0, 0, 32'hFF, 1, 1);
      add(1, 8'hFF, 0, 3, 0, 0, 0, 32'h0, 0, 0);
      add(0, 8'h00, 0, 0, 0, 0, 0, 32'h0, 0, 0);
      add(0, 8'h00, 0, 3, 0, 0, 0, 32'h0, 0, 0);

      rst = 1; src = 0; we = 0; addr = 0; wdata = 0; taken = 0; eret = 0;
      @(posedge clk); #1;

      foreach (vecs[k]) begin
         drive(vecs[k].rst, vecs[k].src, vecs[k].we, vecs[k].addr,
               vecs[k].wdata, vecs[k].taken, vecs[k].eret);
         check($sformatf("vec%0d rdata", k), rdata, vecs[k].exp_rd);
         check($sformatf("vec%0d irq", k), 32'(irq), 32'(vecs[k].exp_irq));
         check($sformatf("vec%0d cause", k), 32'(cause), 32'(vecs[k].exp_cause));
      end

      // randomized run against the reference model
      m_step(1, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 3000; c++) begin
         logic       r, w, t, e;
         logic [7:0] s;
         logic [1:0] a;
         logic [31:0] d;
         r = ($urandom_range(0, 199) == 0);
         s = 8'($urandom) & 8'($urandom);
         w = ($urandom_range(0, 5) == 0);
         a = 2'($urandom);
         d = $urandom;
         if (w && a == 3 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
         t = ($urandom_range(0, 3) == 0);
         e = ($urandom_range(0, 3) == 0);
         m_step(r, s, w, a, d, t, e);
         drive(r, s, w, a, d, t, e);
         check($sformatf("rand%0d rdata", c), rdata, m_read(a));
         check($sformatf("rand%0d irq", c), 32'(irq), 32'(m_state == 1));
         check($sformatf("rand%0d cause", c), 32'(cause), 32'(m_cause));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
